// File: rtl/intr_ack_pkg.sv
// Shared types for the interrupt acknowledge sequencer: FSM states, NMI vector
// and the vector-table word address helper.
package intr_ack_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INTA,
      ST_RD_IP,
      ST_TURN,
      ST_RD_CS,
      ST_DONE
   } state_t;

   localparam logic [7:0] NMI_VECTOR = 8'h02;

   // Each IVT entry is two words: IP at the even word, CS at the odd word.
   function automatic logic [18:0] ivt_addr(input logic [19:0] base,
                                            input logic [7:0]  vec,
                                            input logic        hi);
      return base[19:1] + {10'd0, vec, hi};
   endfunction

endpackage

// File: rtl/intr_ack_edge_latch.sv
// Rising-edge detector feeding a sticky flag; a same-cycle edge beats the clear.
// Flag rises the cycle after the edge; no backpressure.
module edge_latch (
   input  logic clk,
   input  logic reset,
   input  logic din,
   input  logic clr,
   output logic flag
);

   logic din_q;
   logic rise;

   assign rise = din & ~din_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         din_q <= 1'b0;
         flag  <= 1'b0;
      end else begin
         din_q <= din;
         flag  <= rise | (flag & ~clr);
      end
   end

endmodule

// File: rtl/intr_ack.sv
// Interrupt acknowledge sequencer: accepts NMI/INTR at a boundary, pulses inta,
// reads IP then CS from the IVT and holds the entry point until int_taken.
module intr_ack
   import intr_ack_pkg::*;
#(
   parameter logic [19:0] IVT_BASE = 20'h00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        intr,
   input  logic [7:0]  irq,
   output logic        inta,
   input  logic        nmi,
   input  logic        if_flag,
   input  logic        boundary,
   output logic        busy,
   output logic        int_valid,
   output logic [7:0]  int_vector,
   output logic [15:0] int_ip,
   output logic [15:0] int_cs,
   input  logic        int_taken,
   output logic [18:0] mem_m_addr,
   input  logic [15:0] mem_m_data_in,
   output logic        mem_m_access,
   input  logic        mem_m_ack,
   output logic        mem_m_wr_en,
   output logic [1:0]  mem_m_bytesel
);

   state_t state;
   logic   nmi_pending;
   logic   nmi_accept;

   assign nmi_accept = (state == ST_IDLE) & boundary & nmi_pending;

   edge_latch u_nmi_latch (
      .clk   (clk),
      .reset (reset),
      .din   (nmi),
      .clr   (nmi_accept),
      .flag  (nmi_pending)
   );

   // All outputs decode from registered state, so no input reaches an output
   // combinationally.
   assign inta          = (state == ST_INTA);
   assign busy          = (state != ST_IDLE);
   assign int_valid     = (state == ST_DONE);
   assign mem_m_access  = (state == ST_RD_IP) | (state == ST_RD_CS);
   assign mem_m_addr    = ivt_addr(IVT_BASE, int_vector, state == ST_RD_CS);
   assign mem_m_wr_en   = 1'b0;
   assign mem_m_bytesel = 2'b11;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         int_vector <= 8'h00;
         int_ip     <= 16'h0000;
         int_cs     <= 16'h0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (boundary) begin
                  if (nmi_pending) begin
                     int_vector <= NMI_VECTOR;
                     state      <= ST_RD_IP;
                  end else if (intr & if_flag) begin
                     int_vector <= irq;
                     state      <= ST_INTA;
                  end
               end
            end
            ST_INTA: state <= ST_RD_IP;
            ST_RD_IP: begin
               if (mem_m_ack) begin
                  int_ip <= mem_m_data_in;
                  state  <= ST_TURN;
               end
            end
            // Idle bus cycle so a registered-ack slave cannot ack twice.
            ST_TURN: state <= ST_RD_CS;
            ST_RD_CS: begin
               if (mem_m_ack) begin
                  int_cs <= mem_m_data_in;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (int_taken) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ack.sv
// Directed bench for intr_ack with a registered-ack memory model of adjustable latency.
module tb_intr_ack;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        intr = 1'b0;
   logic [7:0]  irq = 8'h00;
   logic        inta;
   logic        nmi = 1'b0;
   logic        if_flag = 1'b0;
   logic        boundary = 1'b0;
   logic        busy;
   logic        int_valid;
   logic [7:0]  int_vector;
   logic [15:0] int_ip;
   logic [15:0] int_cs;
   logic        int_taken = 1'b0;
   logic [18:0] mem_m_addr;
   logic [15:0] mem_m_data_in;
   logic        mem_m_access;
   logic        mem_m_ack;
   logic        mem_m_wr_en;
   logic [1:0]  mem_m_bytesel;

   int vec = 0;
   int errs = 0;

   // Memory model: acks `lat` cycles after access rises, data chosen by word parity.
   int          lat = 1;
   int          mcnt = 0;
   logic        mdl_ack = 1'b0;
   logic [15:0] mdl_data = 16'h0000;
   logic [15:0] ip_val = 16'h0000;
   logic [15:0] cs_val = 16'h0000;
   logic        late_ack = 1'b0;

   assign mem_m_ack     = mdl_ack | late_ack;
   assign mem_m_data_in = late_ack ? 16'hBEEF : mdl_data;

   always @(posedge clk) begin
      if (!mem_m_access || mdl_ack) begin
         mdl_ack <= 1'b0;
         mcnt    <= 0;
      end else if (mcnt == lat - 1) begin
         mdl_ack  <= 1'b1;
         mdl_data <= mem_m_addr[0] ? cs_val : ip_val;
         mcnt     <= 0;
      end else begin
         mcnt <= mcnt + 1;
      end
   end

   always #5 clk = ~clk;

   intr_ack #(.IVT_BASE(20'h00000)) dut (
      .clk           (clk),
      .reset         (reset),
      .intr          (intr),
      .irq           (irq),
      .inta          (inta),
      .nmi           (nmi),
      .if_flag       (if_flag),
      .boundary      (boundary),
      .busy          (busy),
      .int_valid     (int_valid),
      .int_vector    (int_vector),
      .int_ip        (int_ip),
      .int_cs        (int_cs),
      .int_taken     (int_taken),
      .mem_m_addr    (mem_m_addr),
      .mem_m_data_in (mem_m_data_in),
      .mem_m_access  (mem_m_access),
      .mem_m_ack     (mem_m_ack),
      .mem_m_wr_en   (mem_m_wr_en),
      .mem_m_bytesel (mem_m_bytesel)
   );

   task automatic wait_valid(input int bound, output int n);
      n = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (int_valid === 1'b1) begin
            n = i + 1;
            break;
         end
      end
   endtask

   task automatic take;
      int_taken = 1'b1;
      @(negedge clk);
      int_taken = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vec++;
      if ({inta, busy, int_valid, mem_m_access} !== 4'b0000) begin
         errs++;
         $display("FAIL reset_ctrl got %b exp 0000", {inta, busy, int_valid, mem_m_access});
      end
      vec++;
      if ({int_vector, int_ip, int_cs} !== 40'h0) begin
         errs++;
         $display("FAIL reset_data got %h exp 0", {int_vector, int_ip, int_cs});
      end
      vec++;
      if ({mem_m_wr_en, mem_m_bytesel} !== 3'b011) begin
         errs++;
         $display("FAIL reset_bus_const got %b exp 011", {mem_m_wr_en, mem_m_bytesel});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_maskable;
      logic e_inta, e_acc, e_val;
      logic [18:0] e_addr;
      lat = 1; ip_val = 16'h1234; cs_val = 16'hF000;
      intr = 1'b1; irq = 8'h0A; if_flag = 1'b1; boundary = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         boundary = 1'b0;
         if (k == 1) intr = 1'b0;
         e_inta = (k == 1);
         e_acc  = (k == 2) || (k == 3) || (k == 5) || (k == 6);
         e_val  = (k == 7);
         e_addr = (k < 4) ? 19'h00014 : 19'h00015;
         vec++;
         if ({inta, mem_m_access, int_valid, busy} !== {e_inta, e_acc, e_val, k < 8}) begin
            errs++;
            $display("FAIL mask_ctrl k=%0d got %b exp %b", k, {inta, mem_m_access, int_valid, busy},
                     {e_inta, e_acc, e_val, k < 8});
         end
         if (e_acc) begin
            vec++;
            if (mem_m_addr !== e_addr) begin
               errs++;
               $display("FAIL mask_addr k=%0d got %h exp %h", k, mem_m_addr, e_addr);
            end
         end
         if (k == 7) begin
            vec++;
            if ({int_vector, int_ip, int_cs} !== {8'h0A, 16'h1234, 16'hF000}) begin
               errs++;
               $display("FAIL mask_entry got %h/%h/%h exp 0a/1234/f000", int_vector, int_ip, int_cs);
            end
            int_taken = 1'b1;
         end else begin
            int_taken = 1'b0;
         end
      end
   endtask

   task automatic test_nmi_vs_intr;
      int n;
      lat = 1; ip_val = 16'hAAAA; cs_val = 16'h5555;
      nmi = 1'b1;
      @(negedge clk);
      intr = 1'b1; irq = 8'h33; if_flag = 1'b1; boundary = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         boundary = 1'b0;
         vec++;
         if (inta !== 1'b0) begin
            errs++;
            $display("FAIL nmi_no_inta k=%0d got %b exp 0", k, inta);
         end
         if (k == 1 || k == 4) begin
            vec++;
            if (mem_m_access !== 1'b1 || mem_m_addr !== ((k == 1) ? 19'h4 : 19'h5)) begin
               errs++;
               $display("FAIL nmi_addr k=%0d got %b/%h", k, mem_m_access, mem_m_addr);
            end
         end
         if (k == 6) begin
            vec++;
            if ({int_valid, int_vector, int_ip, int_cs} !== {1'b1, 8'h02, 16'hAAAA, 16'h5555}) begin
               errs++;
               $display("FAIL nmi_entry got %b %h/%h/%h exp 1 02/aaaa/5555", int_valid, int_vector, int_ip, int_cs);
            end
            int_taken = 1'b1;
         end else begin
            int_taken = 1'b0;
         end
      end
      nmi = 1'b0;
      boundary = 1'b1;
      @(negedge clk);
      boundary = 1'b0;
      intr = 1'b0;
      vec++;
      if ({inta, int_vector} !== {1'b1, 8'h33}) begin
         errs++;
         $display("FAIL nmi_then_intr got %b/%h exp 1/33", inta, int_vector);
      end
      @(negedge clk);
      vec++;
      if (mem_m_addr !== 19'h00066) begin
         errs++;
         $display("FAIL nmi_then_intr_addr got %h exp 00066", mem_m_addr);
      end
      wait_valid(20, n);
      vec++;
      if (n < 0) begin
         errs++;
         $display("FAIL nmi_then_intr_done got timeout exp int_valid");
      end
      take();
   endtask

   task automatic test_if_flag;
      int n;
      intr = 1'b1; irq = 8'h44; if_flag = 1'b0; boundary = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         boundary = 1'b0;
         vec++;
         if ({busy, inta} !== 2'b00) begin
            errs++;
            $display("FAIL iflag_masked k=%0d got %b exp 00", k, {busy, inta});
         end
      end
      nmi = 1'b1;
      @(negedge clk);
      boundary = 1'b1;
      @(negedge clk);
      boundary = 1'b0;
      vec++;
      if ({busy, inta, mem_m_access, mem_m_addr} !== {3'b101, 19'h4}) begin
         errs++;
         $display("FAIL iflag_nmi got %b %h exp 101 00004", {busy, inta, mem_m_access}, mem_m_addr);
      end
      intr = 1'b0; nmi = 1'b0;
      wait_valid(20, n);
      vec++;
      if (n < 0) begin
         errs++;
         $display("FAIL iflag_nmi_done got timeout exp int_valid");
      end
      take();
   endtask

   task automatic test_wait_states;
      logic e_acc, e_val;
      lat = 3; ip_val = 16'hC0DE; cs_val = 16'h0F0F;
      intr = 1'b1; irq = 8'h81; if_flag = 1'b1; boundary = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         boundary = 1'b0;
         if (k == 1) intr = 1'b0;
         e_acc = (k >= 2 && k <= 5) || (k >= 7 && k <= 10);
         e_val = (k >= 11 && k <= 15);
         vec++;
         if ({inta, mem_m_access, int_valid} !== {k == 1, e_acc, e_val}) begin
            errs++;
            $display("FAIL wait_ctrl k=%0d got %b exp %b", k, {inta, mem_m_access, int_valid}, {k == 1, e_acc, e_val});
         end
         if (e_acc) begin
            vec++;
            if (mem_m_addr !== ((k < 6) ? 19'h00102 : 19'h00103)) begin
               errs++;
               $display("FAIL wait_addr k=%0d got %h", k, mem_m_addr);
            end
         end
         if (e_val) begin
            vec++;
            if ({int_vector, int_ip, int_cs} !== {8'h81, 16'hC0DE, 16'h0F0F}) begin
               errs++;
               $display("FAIL wait_hold k=%0d got %h/%h/%h exp 81/c0de/0f0f", k, int_vector, int_ip, int_cs);
            end
         end
         int_taken = (k == 15);
      end
      vec++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL wait_release got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      lat = 3; ip_val = 16'h1111; cs_val = 16'h2222;
      intr = 1'b1; irq = 8'h10; if_flag = 1'b1; boundary = 1'b1;
      n = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         boundary = 1'b0;
         intr = 1'b0;
         if (mem_m_access === 1'b1 && mem_m_addr[0] === 1'b1) begin
            n = i;
            break;
         end
      end
      vec++;
      if (n < 0) begin
         errs++;
         $display("FAIL rstmid_reach got timeout exp RD_CS");
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      late_ack = 1'b1;
      vec++;
      if ({inta, busy, int_valid, mem_m_access, int_vector, int_ip, int_cs} !== 44'h0) begin
         errs++;
         $display("FAIL rstmid_outputs got %b %h/%h/%h exp all 0", {inta, busy, int_valid, mem_m_access},
                  int_vector, int_ip, int_cs);
      end
      @(negedge clk);
      late_ack = 1'b0;
      @(negedge clk);
      vec++;
      if ({busy, mem_m_access, int_cs} !== 18'h0) begin
         errs++;
         $display("FAIL rstmid_late_ack got %b/%h exp 0/0000", {busy, mem_m_access}, int_cs);
      end
   endtask

   task automatic test_nmi_while_busy;
      int n;
      lat = 1; ip_val = 16'h7777; cs_val = 16'h8888;
      intr = 1'b1; irq = 8'h20; if_flag = 1'b1; boundary = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         boundary = (k == 2);
         if (k == 1) intr = 1'b0;
         if (k == 2) nmi = 1'b1;
         if (k == 7) begin
            vec++;
            if ({int_valid, int_vector, int_ip, int_cs} !== {1'b1, 8'h20, 16'h7777, 16'h8888}) begin
               errs++;
               $display("FAIL busy_seq got %b %h/%h/%h exp 1 20/7777/8888", int_valid, int_vector, int_ip, int_cs);
            end
         end
         int_taken = (k == 7);
      end
      vec++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL busy_boundary_ignored got busy=%b exp 0", busy);
      end
      boundary = 1'b1;
      @(negedge clk);
      boundary = 1'b0;
      nmi = 1'b0;
      vec++;
      if ({busy, inta, int_vector, mem_m_addr} !== {2'b10, 8'h02, 19'h4}) begin
         errs++;
         $display("FAIL busy_nmi_later got %b %h %h exp 10 02 00004", {busy, inta}, int_vector, mem_m_addr);
      end
      wait_valid(20, n);
      vec++;
      if (n < 0) begin
         errs++;
         $display("FAIL busy_nmi_done got timeout exp int_valid");
      end
      take();
   endtask

   initial begin
      test_reset();
      test_maskable();
      test_nmi_vs_intr();
      test_if_flag();
      test_wait_states();
      test_reset_mid();
      test_nmi_while_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp end of tests");
      $fatal(1);
   end

endmodule
